// File: rtl/decode_pipe_if.sv
// decode_pipe_if -- handshake and field bus around the decode_pipe stage.
//
// Carries the fetch-side push channel (in_valid/in_ready/insn/pc), the
// execute-side pop channel (out_valid/out_ready) and the decoded head-entry
// fields. The master modport is the fetch/execute side that drives the
// instruction and consumes decoded entries. The slave modport is the decode
// stage itself.
//
// Parameters: PC_WIDTH (PC width), XLEN (imm_out width, >= 32),
//             DEPTH (queue entries, power of two, >= 2).
interface decode_pipe_if #(
  parameter int PC_WIDTH = 32,
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                in_valid;
  logic                in_ready;
  logic [31:0]         insn;
  logic [PC_WIDTH-1:0] pc;
  logic                out_valid;
  logic                out_ready;
  logic [5:0]          opcode_out;
  logic [4:0]          rs_out;
  logic [4:0]          rt_out;
  logic [4:0]          rd_out;
  logic [4:0]          sa_out;
  logic [5:0]          func_out;
  logic [XLEN-1:0]     imm_out;
  logic [PC_WIDTH-1:0] pc_out;
  logic [1:0]          class_out;
  logic                writes_reg_out;
  logic                illegal_out;
  logic [CW-1:0]       count_out;

  modport master (
    output in_valid, insn, pc, out_ready,
    input  in_ready, out_valid, opcode_out, rs_out, rt_out, rd_out, sa_out,
           func_out, imm_out, pc_out, class_out, writes_reg_out, illegal_out,
           count_out
  );

  modport slave (
    input  in_valid, insn, pc, out_ready,
    output in_ready, out_valid, opcode_out, rs_out, rt_out, rd_out, sa_out,
           func_out, imm_out, pc_out, class_out, writes_reg_out, illegal_out,
           count_out
  );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe -- elastic MIPS instruction decode stage.
//
// Each accepted instruction is decoded combinationally into canonical fields
// (unused fields forced to zero, immediate extended to XLEN, GPR-write
// classification) and written into the tail of a DEPTH-entry queue. The head
// entry drives the decoded outputs straight from storage.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset (clears queue and all storage)
//   flush    synchronous queue clear; a push in the same cycle is dropped
//   bus      decode_pipe_if.slave: push channel, pop channel, head fields
//
// Build option: define DECODE_ILLEGAL_EN to emit unsupported encodings as
// entries flagged illegal_out=1 (opcode/func kept, other fields 0). Without
// it, unsupported encodings decode as NOP and illegal_out stays 0.
module decode_pipe #(
  parameter int PC_WIDTH = 32,
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2
) (
  input logic          clock,
  input logic          reset_n,
  input logic          flush,
  decode_pipe_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [5:0]          op;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [4:0]          sa;
    logic [5:0]          fn;
    logic [XLEN-1:0]     imm;
    logic [PC_WIDTH-1:0] pc;
    logic [1:0]          cls;
    logic                wr;
    logic                ill;
  } entry_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

  // Branch offsets are word counts, so the byte offset is the sign-extended
  // field shifted left by two.
  function automatic logic [XLEN-1:0] br_off(input logic [15:0] v);
    return {{(XLEN-18){v[15]}}, v, 2'b00};
  endfunction

  function automatic entry_t decode(input logic [31:0] ins);
    entry_t     d;
    logic [5:0] op;
    logic [5:0] fn;
    logic       legal;
    logic       itype;
    logic       wr_rt;
    op    = ins[31:26];
    fn    = ins[5:0];
    d     = '0;
    legal = 1'b1;
    itype = 1'b0;
    wr_rt = 1'b0;
    case (op)
      6'h00: begin
        d.cls = 2'd0;
        d.rs  = ins[25:21];
        d.rt  = ins[20:16];
        d.rd  = ins[15:11];
        d.fn  = fn;
        case (fn)
          6'h18, 6'h19, 6'h1A, 6'h1B: d.rd = '0;           // MULT/DIV write HI/LO
          6'h10, 6'h12: begin                              // MFHI/MFLO
            d.rs = '0;
            d.rt = '0;
          end
          6'h00, 6'h02, 6'h03: begin                       // constant shifts
            d.rs = '0;
            d.sa = ins[10:6];
          end
          6'h08: begin                                     // JR
            d.rt = '0;
            d.rd = '0;
          end
          6'h04, 6'h06, 6'h07, 6'h09,
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: ;                                  // sa stays 0
          default: legal = 1'b0;
        endcase
        // rd has already been zeroed for MULT*/DIV*/JR, so a non-zero rd is
        // exactly the GPR-write condition for R-type.
        d.wr = |d.rd;
      end
      6'h01: begin                                         // REGIMM BLTZ/BGEZ
        itype = 1'b1;
        d.imm = br_off(ins[15:0]);
        legal = (ins[20:17] == 4'd0);
      end
      6'h02, 6'h03: begin
        d.cls = 2'd2;
        d.imm = XLEN'(ins[25:0]);
        if (op[0]) begin                                   // JAL links to $31
          d.rd = 5'd31;
          d.wr = 1'b1;
        end
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        itype = 1'b1;
        d.imm = br_off(ins[15:0]);
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20, 6'h23, 6'h24: begin
        itype = 1'b1;
        wr_rt = 1'b1;
        d.imm = sext16(ins[15:0]);
      end
      6'h0C, 6'h0D, 6'h0E: begin
        itype = 1'b1;
        wr_rt = 1'b1;
        d.imm = XLEN'(ins[15:0]);
      end
      6'h0F: begin
        itype = 1'b1;
        wr_rt = 1'b1;
        d.imm = XLEN'({ins[15:0], 16'h0000});
      end
      6'h28, 6'h2B: begin
        itype = 1'b1;
        d.imm = sext16(ins[15:0]);
      end
      default: legal = 1'b0;
    endcase
    if (itype) begin
      d.cls = 2'd1;
      d.rs  = ins[25:21];
      d.rt  = ins[20:16];
      d.wr  = wr_rt && (ins[20:16] != 5'd0);
    end
    d.op = op;
    if (!legal) begin
      d = '0;
`ifdef DECODE_ILLEGAL_EN
      d.op  = op;
      d.fn  = fn;
      d.ill = 1'b1;
      d.cls = (op == 6'h00) ? 2'd0 : ((op == 6'h02 || op == 6'h03) ? 2'd2 : 2'd1);
`else
      d.cls = 2'd3;
`endif
    end
    if (ins == 32'h0000_0000) begin
      d     = '0;
      d.cls = 2'd3;
    end
    return d;
  endfunction

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  entry_t        new_entry;
  entry_t        head;

  // Ready depends only on registered occupancy: a full queue never accepts,
  // even when the head is being consumed in the same cycle.
  assign bus.in_ready  = reset_n && (count_q < CW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid && bus.in_ready && !flush;
  assign pop           = bus.out_valid && bus.out_ready && !flush;

  always_comb begin
    new_entry    = decode(bus.insn);
    new_entry.pc = bus.pc;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign head               = mem_q[rd_ptr_q];
  assign bus.opcode_out     = head.op;
  assign bus.rs_out         = head.rs;
  assign bus.rt_out         = head.rt;
  assign bus.rd_out         = head.rd;
  assign bus.sa_out         = head.sa;
  assign bus.func_out       = head.fn;
  assign bus.imm_out        = head.imm;
  assign bus.pc_out         = head.pc;
  assign bus.class_out      = head.cls;
  assign bus.writes_reg_out = head.wr;
  assign bus.illegal_out    = head.ill;
  assign bus.count_out      = count_q;
endmodule

// File: tb/tb_decode_pipe.sv
module tb_decode_pipe;
  logic clock = 1'b0;
  logic reset_n;
  logic flush;

  always #5 clock = ~clock;

  decode_pipe_if #(.PC_WIDTH(32), .XLEN(32), .DEPTH(2)) bus();

  decode_pipe #(.PC_WIDTH(32), .XLEN(32), .DEPTH(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] insn;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [1:0]  cls;
    logic        wr;
    logic        ill;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //        insn          op     rs     rt     rd     sa     fn     imm           cls   wr    ill
    vt[0]  = '{32'h00221821, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h21, 32'h00000000, 2'd0, 1'b1, 1'b0}; // ADDU
    vt[1]  = '{32'h2405FFFF, 6'h09, 5'd0,  5'd5,  5'd0,  5'd0,  6'h00, 32'hFFFFFFFF, 2'd1, 1'b1, 1'b0}; // ADDIU
    vt[2]  = '{32'h3405FFFF, 6'h0D, 5'd0,  5'd5,  5'd0,  5'd0,  6'h00, 32'h0000FFFF, 2'd1, 1'b1, 1'b0}; // ORI
    vt[3]  = '{32'h1022FFFF, 6'h04, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 32'hFFFFFFFC, 2'd1, 1'b0, 1'b0}; // BEQ
    vt[4]  = '{32'h0C100000, 6'h03, 5'd0,  5'd0,  5'd31, 5'd0,  6'h00, 32'h00100000, 2'd2, 1'b1, 1'b0}; // JAL
    vt[5]  = '{32'h00011100, 6'h00, 5'd0,  5'd1,  5'd2,  5'd4,  6'h00, 32'h00000000, 2'd0, 1'b1, 1'b0}; // SLL
    vt[6]  = '{32'h00000000, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h00000000, 2'd3, 1'b0, 1'b0}; // NOP
    vt[7]  = '{32'h002228D8, 6'h00, 5'd1,  5'd2,  5'd0,  5'd0,  6'h18, 32'h00000000, 2'd0, 1'b0, 1'b0}; // MULT, rd/sa junk
    vt[8]  = '{32'h00E32050, 6'h00, 5'd0,  5'd0,  5'd4,  5'd0,  6'h10, 32'h00000000, 2'd0, 1'b1, 1'b0}; // MFHI, rs/rt/sa junk
    vt[9]  = '{32'h03E22848, 6'h00, 5'd31, 5'd0,  5'd0,  5'd0,  6'h08, 32'h00000000, 2'd0, 1'b0, 1'b0}; // JR, rt/rd/sa junk
    vt[10] = '{32'h00220060, 6'h00, 5'd1,  5'd2,  5'd0,  5'd0,  6'h20, 32'h00000000, 2'd0, 1'b0, 1'b0}; // ADD rd=0, sa junk
    vt[11] = '{32'h3C041234, 6'h0F, 5'd0,  5'd4,  5'd0,  5'd0,  6'h00, 32'h12340000, 2'd1, 1'b1, 1'b0}; // LUI
    vt[12] = '{32'hAC450008, 6'h2B, 5'd2,  5'd5,  5'd0,  5'd0,  6'h00, 32'h00000008, 2'd1, 1'b0, 1'b0}; // SW
    vt[13] = '{32'h8C20FFFC, 6'h23, 5'd1,  5'd0,  5'd0,  5'd0,  6'h00, 32'hFFFFFFFC, 2'd1, 1'b0, 1'b0}; // LW rt=0
    vt[14] = '{32'h04610001, 6'h01, 5'd3,  5'd1,  5'd0,  5'd0,  6'h00, 32'h00000004, 2'd1, 1'b0, 1'b0}; // BGEZ
`ifdef DECODE_ILLEGAL_EN
    vt[15] = '{32'hFC000000, 6'h3F, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h00000000, 2'd1, 1'b0, 1'b1};
    vt[16] = '{32'h00000001, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h01, 32'h00000000, 2'd0, 1'b0, 1'b1};
`else
    vt[15] = '{32'hFC000000, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h00000000, 2'd3, 1'b0, 1'b0};
    vt[16] = '{32'h00000001, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h00000000, 2'd3, 1'b0, 1'b0};
`endif

    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.insn      = 32'h0;
    bus.pc        = 32'h0;
    tick();
    tick();
    chk("rst_in_ready",  64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count",     64'(bus.count_out), 64'd0);
    chk("rst_imm",       64'(bus.imm_out), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("rel_in_ready",  64'(bus.in_ready), 64'd1);

    // Back-to-back stream with out_ready held: each entry reaches the head
    // one edge after it is offered, while the previous one is consumed.
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      bus.in_valid = 1'b1;
      bus.insn     = vt[i].insn;
      bus.pc       = 32'h1000 + 32'(i * 4);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d_count", i), 64'(bus.count_out), 64'd1);
      chk($sformatf("v%0d_op", i),    64'(bus.opcode_out), 64'(vt[i].op));
      chk($sformatf("v%0d_rs", i),    64'(bus.rs_out), 64'(vt[i].rs));
      chk($sformatf("v%0d_rt", i),    64'(bus.rt_out), 64'(vt[i].rt));
      chk($sformatf("v%0d_rd", i),    64'(bus.rd_out), 64'(vt[i].rd));
      chk($sformatf("v%0d_sa", i),    64'(bus.sa_out), 64'(vt[i].sa));
      chk($sformatf("v%0d_fn", i),    64'(bus.func_out), 64'(vt[i].fn));
      chk($sformatf("v%0d_imm", i),   64'(bus.imm_out), 64'(vt[i].imm));
      chk($sformatf("v%0d_cls", i),   64'(bus.class_out), 64'(vt[i].cls));
      chk($sformatf("v%0d_wr", i),    64'(bus.writes_reg_out), 64'(vt[i].wr));
      chk($sformatf("v%0d_ill", i),   64'(bus.illegal_out), 64'(vt[i].ill));
      chk($sformatf("v%0d_pc", i),    64'(bus.pc_out), 64'(32'h1000 + 32'(i * 4)));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_count", 64'(bus.count_out), 64'd0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // Fill to full with execute stalled.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.insn      = 32'h00221821;
    tick();
    chk("fill1_count", 64'(bus.count_out), 64'd1);
    chk("fill1_ready", 64'(bus.in_ready), 64'd1);
    bus.insn = 32'h00011100;
    tick();
    chk("fill2_count", 64'(bus.count_out), 64'd2);
    chk("fill2_ready", 64'(bus.in_ready), 64'd0);
    chk("fill2_head",  64'(bus.rd_out), 64'd3);
    bus.insn = 32'h2405FFFF;
    tick();
    chk("full_count",  64'(bus.count_out), 64'd2);
    chk("full_ready",  64'(bus.in_ready), 64'd0);
    chk("full_hold",   64'(bus.rd_out), 64'd3);
    chk("full_holdfn", 64'(bus.func_out), 64'h21);

    // Full and popping with in_valid still high: only the pop happens.
    bus.out_ready = 1'b1;
    tick();
    chk("nopass_count", 64'(bus.count_out), 64'd1);
    chk("nopass_ready", 64'(bus.in_ready), 64'd1);
    chk("nopass_rd",    64'(bus.rd_out), 64'd2);
    chk("nopass_sa",    64'(bus.sa_out), 64'd4);

    // Push and pop together at count 1.
    tick();
    chk("pp_count", 64'(bus.count_out), 64'd1);
    chk("pp_rt",    64'(bus.rt_out), 64'd5);
    chk("pp_imm",   64'(bus.imm_out), 64'hFFFFFFFF);

    // Flush with a push offered: queue empties, push dropped.
    flush         = 1'b1;
    bus.out_ready = 1'b0;
    bus.insn      = 32'h00221821;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", 64'(bus.count_out), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("flush_stay",  64'(bus.count_out), 64'd0);

    // Reset with two entries queued.
    bus.in_valid = 1'b1;
    bus.insn     = 32'h0C100000;
    bus.pc       = 32'h0000ABC0;
    tick();
    bus.insn = 32'h3C041234;
    tick();
    chk("prerst_count", 64'(bus.count_out), 64'd2);
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    tick();
    chk("mrst_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_ready", 64'(bus.in_ready), 64'd0);
    chk("mrst_count", 64'(bus.count_out), 64'd0);
    chk("mrst_op",    64'(bus.opcode_out), 64'd0);
    chk("mrst_rd",    64'(bus.rd_out), 64'd0);
    chk("mrst_imm",   64'(bus.imm_out), 64'd0);
    chk("mrst_pc",    64'(bus.pc_out), 64'd0);
    chk("mrst_wr",    64'(bus.writes_reg_out), 64'd0);
    chk("mrst_cls",   64'(bus.class_out), 64'd0);
    chk("mrst_fields", 64'({bus.rs_out, bus.rt_out, bus.sa_out, bus.func_out, bus.illegal_out}), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("mrel_ready", 64'(bus.in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
